i2c_byte_sequencer: RTL and testbench
=====================================

# i2c_byte_sequencer

Byte-level transaction controller for the I2C master, in the `i2c_core_clk_i` domain between the TX/RX data FIFOs and the bit-level SCL/SDA engine. It does four things:
- sequences START, address, data bytes, repeated START and STOP;
- pops TX-FIFO bytes for writes and pushes received bytes into the RX-FIFO for reads;
- stalls on TX empty and RX full;
- reports busy, done and NACK errors.

## Interface
Parameters:
- `DATASIZE`, 8, byte width
- `CNTSIZE`, 8, width of byte counter

Ports:
- `i2c_core_clk_i`  in  1  core clock; all logic is on the rising edge
- `i2c_core_rst_i`  in  1  asynchronous, active-high reset
- `enable_i`  in  1  level; requests a transaction, sampled in IDLE and at end of transfer
- `rw_i`  in  1  1 = read, 0 = write; sampled with `enable_i`
- `repeat_start_i`  in  1  at end of transfer, issue repeated START instead of STOP
- `slave_addr_i`  in  7  target address
- `byte_count_i`  in  CNTSIZE  data bytes per transfer; 0 = address only
- `tx_empty_i`  in  1  TX-FIFO empty
- `rx_full_i`  in  1  RX-FIFO full
- `tx_data_i`  in  DATASIZE  TX-FIFO head data, valid while `!tx_empty_i`
- `r_tx_fifo_en_o`  out  1  one-cycle TX-FIFO pop
- `w_rx_fifo_en_o`  out  1  one-cycle RX-FIFO push
- `rx_data_o`  out  DATASIZE  RX-FIFO write data, held from the push cycle until the next push
- `start_cond_o`  out  1  one-cycle request to engine: (repeated) START
- `stop_cond_o`  out  1  one-cycle request to engine: STOP
- `cond_done_i`  in  1  one-cycle pulse; engine finished the requested condition
- `byte_start_o`  out  1  one-cycle request to engine: shift one byte
- `byte_o`  out  DATASIZE  byte to transmit, stable from `byte_start_o` to `byte_done_i`
- `byte_is_read_o`  out  1  current byte is a read
- `ack_to_send_o`  out  1  master ACK bit for a read byte: 0 = ACK, 1 = NACK
- `byte_done_i`  in  1  one-cycle pulse; byte plus ACK bit complete
- `ack_rcvd_i`  in  1  slave ACK bit sampled with `byte_done_i` (0 = ACK)
- `byte_rcvd_i`  in  DATASIZE  received byte, valid with `byte_done_i`
- `busy_o`  out  1  high in every state except IDLE
- `done_o`  out  1  one-cycle pulse when STOP completes
- `nack_err_o`  out  1  sticky; set on slave NACK, cleared on next IDLE→START

## Operation
- States: IDLE, START, ADDR, TX_FETCH, TX_WAIT, RX_WAIT, RX_STORE, STOP.
- All request pulses (`start_cond_o`, `stop_cond_o`, `byte_start_o`) are registered and asserted only in the first cycle of their state.
- IDLE:
  - `enable_i`=1 → START.
  - Latch `rw_i`, `slave_addr_i`, `byte_count_i` into `cnt`.
- START: pulse `start_cond_o`. On `cond_done_i` → ADDR.
- ADDR:
  - `byte_o`={addr,rw}, `byte_is_read_o`=0; pulse `byte_start_o`.
  - On `byte_done_i`:
    - `ack_rcvd_i`=1 → set `nack_err_o`, go STOP.
    - `cnt`==0 → END.
    - rw=0 → TX_FETCH; rw=1 → RX_WAIT (with `byte_start_o`).
- TX_FETCH:
  - Wait while `tx_empty_i`.
  - When not empty: latch `tx_data_i` into `byte_o`, pulse `r_tx_fifo_en_o` in that same cycle, → TX_WAIT with `byte_start_o`.
- TX_WAIT: on `byte_done_i`, decrement `cnt`.
  - NACK → set `nack_err_o`, STOP; no further pops.
  - `cnt` reaches 0 → END.
  - Otherwise → TX_FETCH.
- RX_WAIT:
  - `byte_is_read_o`=1; `ack_to_send_o`=1 iff `cnt`==1, else 0.
  - On `byte_done_i`: capture `byte_rcvd_i`, decrement `cnt`, → RX_STORE.
- RX_STORE:
  - Wait while `rx_full_i`, holding the captured byte.
  - When not full: pulse `w_rx_fifo_en_o` with `rx_data_o` = captured byte.
  - Then `cnt`==0 → END, else → RX_WAIT with `byte_start_o`.
- END (decision, no extra cycle):
  - `repeat_start_i`=1 and `enable_i`=1 → START; re-latch rw/addr/count; `nack_err_o` is kept.
  - Otherwise → STOP.
- STOP: pulse `stop_cond_o`. On `cond_done_i`: pulse `done_o`, → IDLE.
- `cnt` is CNTSIZE bits, unsigned, never decremented below 0. `byte_count_i`=0 never touches either FIFO.

## Timing
- Reset: state IDLE; every output 0; `cnt`=0; captured byte 0.
- Reset mid-transfer aborts immediately with no STOP issued; FIFOs are reset separately.
- `enable_i` high at edge N → `busy_o` and `start_cond_o` high at cycle N+1.
- TX pop to `byte_start_o`: same cycle (FIFO read is combinational from the head).
- Stall latency: pop or push occurs in the first cycle after `tx_empty_i` or `rx_full_i` goes low.
- `byte_done_i` in a write byte → next `byte_start_o` ≥1 cycle later.
- Last `cond_done_i` of STOP at edge M → `done_o` at cycle M+1 and `busy_o`=0 at cycle M+1.
- Request or done inputs arriving in an unrelated state are ignored.
- `enable_i` dropping mid-transfer has no effect until END.

## Test plan
- **Write 3 bytes:** addr 0x50, rw=0, count=3, TX-FIFO holds A1,A2,A3 → START; byte 0xA0; three pops, with bytes A1,A2,A3; STOP; one `done_o`; `nack_err_o`=0.
- **Read 2 bytes:** count=2, engine returns 5C,C5 → `ack_to_send_o` 0 then 1; two pushes carrying 5C then C5; `byte_o` for address = 0xA1.
- **Address NACK:** `ack_rcvd_i`=1 on address → no pops; STOP; `nack_err_o`=1 until next START.
- **Stalls:**
  - TX empty 10 cycles before the 2nd byte → no `byte_start_o` during the stall; pop on the first non-empty cycle.
  - RX full → push delayed; `rx_data_o` correct.
- **Repeated START:** write 1 byte, `repeat_start_i`=1, then read 1 byte → exactly two `start_cond_o`, one `stop_cond_o`.
- **Reset mid-TX_WAIT:** all outputs are 0 the cycle after assertion; next `enable_i` starts cleanly; count=0 gives address only with no FIFO activity.

Source files
------------

// File: rtl/i2c_byte_sequencer.sv
// Byte-level I2C master sequencer: walks START, address, data bytes, repeated START and STOP,
// moving bytes between the TX/RX FIFOs and the bit engine with stall handling.
module i2c_byte_sequencer #(
    parameter int DATASIZE = 8,
    parameter int CNTSIZE  = 8
) (
    input  logic                i2c_core_clk_i,
    input  logic                i2c_core_rst_i,
    input  logic                enable_i,
    input  logic                rw_i,
    input  logic                repeat_start_i,
    input  logic [6:0]          slave_addr_i,
    input  logic [CNTSIZE-1:0]  byte_count_i,
    input  logic                tx_empty_i,
    input  logic                rx_full_i,
    input  logic [DATASIZE-1:0] tx_data_i,
    output logic                r_tx_fifo_en_o,
    output logic                w_rx_fifo_en_o,
    output logic [DATASIZE-1:0] rx_data_o,
    output logic                start_cond_o,
    output logic                stop_cond_o,
    input  logic                cond_done_i,
    output logic                byte_start_o,
    output logic [DATASIZE-1:0] byte_o,
    output logic                byte_is_read_o,
    output logic                ack_to_send_o,
    input  logic                byte_done_i,
    input  logic                ack_rcvd_i,
    input  logic [DATASIZE-1:0] byte_rcvd_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                nack_err_o
);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, TX_FETCH, TX_WAIT, RX_WAIT, RX_STORE, STOP
    } state_t;

    state_t               state;
    logic                 rw;
    logic [6:0]           addr;
    logic [CNTSIZE-1:0]   cnt;
    logic [DATASIZE-1:0]  rx_byte;
    logic                 at_end;
    logic                 restart;

    // at_end marks the cycle whose transition would otherwise land on the END decision point
    always_comb begin
        at_end = 1'b0;
        case (state)
            ADDR:     at_end = byte_done_i && !ack_rcvd_i && (cnt == '0);
            TX_WAIT:  at_end = byte_done_i && !ack_rcvd_i && (cnt <= CNTSIZE'(1));
            RX_STORE: at_end = !rx_full_i && (cnt == '0);
            default:  at_end = 1'b0;
        endcase
    end

    assign restart = repeat_start_i & enable_i;

    always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
        if (i2c_core_rst_i) begin
            state          <= IDLE;
            rw             <= 1'b0;
            addr           <= '0;
            cnt            <= '0;
            rx_byte        <= '0;
            r_tx_fifo_en_o <= 1'b0;
            w_rx_fifo_en_o <= 1'b0;
            rx_data_o      <= '0;
            start_cond_o   <= 1'b0;
            stop_cond_o    <= 1'b0;
            byte_start_o   <= 1'b0;
            byte_o         <= '0;
            byte_is_read_o <= 1'b0;
            ack_to_send_o  <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            nack_err_o     <= 1'b0;
        end else begin
            r_tx_fifo_en_o <= 1'b0;
            w_rx_fifo_en_o <= 1'b0;
            start_cond_o   <= 1'b0;
            stop_cond_o    <= 1'b0;
            byte_start_o   <= 1'b0;
            done_o         <= 1'b0;

            case (state)
                IDLE: if (enable_i) begin
                    state        <= START;
                    start_cond_o <= 1'b1;
                    busy_o       <= 1'b1;
                    nack_err_o   <= 1'b0;
                    rw           <= rw_i;
                    addr         <= slave_addr_i;
                    cnt          <= byte_count_i;
                end
                START: if (cond_done_i) begin
                    state          <= ADDR;
                    byte_start_o   <= 1'b1;
                    byte_o         <= DATASIZE'({addr, rw});
                    byte_is_read_o <= 1'b0;
                end
                ADDR: if (byte_done_i) begin
                    if (ack_rcvd_i) begin
                        nack_err_o  <= 1'b1;
                        stop_cond_o <= 1'b1;
                        state       <= STOP;
                    end else if (!rw) begin
                        state <= TX_FETCH;
                    end else begin
                        state          <= RX_WAIT;
                        byte_start_o   <= 1'b1;
                        byte_is_read_o <= 1'b1;
                        ack_to_send_o  <= (cnt == CNTSIZE'(1));
                    end
                end
                TX_FETCH: if (!tx_empty_i) begin
                    byte_o         <= tx_data_i;
                    r_tx_fifo_en_o <= 1'b1;
                    byte_start_o   <= 1'b1;
                    state          <= TX_WAIT;
                end
                TX_WAIT: if (byte_done_i) begin
                    if (cnt != '0) cnt <= cnt - CNTSIZE'(1);
                    if (ack_rcvd_i) begin
                        nack_err_o  <= 1'b1;
                        stop_cond_o <= 1'b1;
                        state       <= STOP;
                    end else begin
                        state <= TX_FETCH;
                    end
                end
                RX_WAIT: if (byte_done_i) begin
                    rx_byte <= byte_rcvd_i;
                    if (cnt != '0) cnt <= cnt - CNTSIZE'(1);
                    state <= RX_STORE;
                end
                RX_STORE: if (!rx_full_i) begin
                    w_rx_fifo_en_o <= 1'b1;
                    rx_data_o      <= rx_byte;
                    byte_start_o   <= 1'b1;
                    ack_to_send_o  <= (cnt == CNTSIZE'(1));
                    state          <= RX_WAIT;
                end
                STOP: if (cond_done_i) begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            // END decision overrides the per-state transition above; the sticky NACK flag survives a restart
            if (at_end) begin
                byte_start_o   <= 1'b0;
                byte_is_read_o <= 1'b0;
                ack_to_send_o  <= 1'b0;
                if (restart) begin
                    state        <= START;
                    start_cond_o <= 1'b1;
                    rw           <= rw_i;
                    addr         <= slave_addr_i;
                    cnt          <= byte_count_i;
                end else begin
                    state       <= STOP;
                    stop_cond_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Bench for i2c_byte_sequencer: FIFO and bit-engine models respond each cycle, and every
// transaction's logged activity is compared with a rule-based expectation.
module tb_i2c_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0, rw = 1'b0, repeat_start = 1'b0;
    logic [6:0] slave_addr = '0;
    logic [7:0] byte_count = '0;
    logic       tx_empty = 1'b1, rx_full = 1'b0;
    logic [7:0] tx_data = '0;
    logic       cond_done = 1'b0, byte_done = 1'b0, ack_rcvd = 1'b0;
    logic [7:0] byte_rcvd = '0;

    logic       r_tx_fifo_en, w_rx_fifo_en, start_cond, stop_cond, byte_start;
    logic [7:0] rx_data, byte_val;
    logic       byte_is_read, ack_to_send, busy, done, nack_err;

    i2c_byte_sequencer #(.DATASIZE(8), .CNTSIZE(8)) dut (
        .i2c_core_clk_i(clk), .i2c_core_rst_i(rst),
        .enable_i(enable), .rw_i(rw), .repeat_start_i(repeat_start),
        .slave_addr_i(slave_addr), .byte_count_i(byte_count),
        .tx_empty_i(tx_empty), .rx_full_i(rx_full), .tx_data_i(tx_data),
        .r_tx_fifo_en_o(r_tx_fifo_en), .w_rx_fifo_en_o(w_rx_fifo_en), .rx_data_o(rx_data),
        .start_cond_o(start_cond), .stop_cond_o(stop_cond), .cond_done_i(cond_done),
        .byte_start_o(byte_start), .byte_o(byte_val), .byte_is_read_o(byte_is_read),
        .ack_to_send_o(ack_to_send), .byte_done_i(byte_done), .ack_rcvd_i(ack_rcvd),
        .byte_rcvd_i(byte_rcvd), .busy_o(busy), .done_o(done), .nack_err_o(nack_err)
    );

    initial forever #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int cond_cd = 0, byte_cd = 0, tx_hold = 0, rx_hold = 0;
    bit cond_stop = 0, ack_plan = 0, plan_is_read = 0;
    logic [7:0] rd_plan = '0, popv;
    int byte_idx = 0, rd_done = 0;
    int nack_at = -1, tx_stall_after = 0, tx_stall_len = 0, rx_stall_after = 0, rx_stall_len = 0;
    int max_delay = 2;
    int tx_low_cyc = 0, rx_low_cyc = 0, stop_cd_cyc = 0, done_cyc = 0;
    logic busy_at_done = 1'b0;
    int n_start = 0, n_stop = 0, n_done = 0;
    bit exp_nack = 0;

    logic [7:0] tx_q[$], rx_src[$], cur_data[$];
    logic [7:0] bs_byte[$], pop_q[$], push_q[$];
    bit         bs_read[$], bs_ack[$];
    int         bs_cyc[$], pop_cyc[$], push_cyc[$];
    logic [7:0] exp_bytes[$], exp_pop[$], exp_push[$];
    bit         exp_read[$], exp_ack[$];

    // Bit engine and FIFO models: engine pulses first, then observe the DUT, then FIFO status
    initial begin : bus
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                cond_cd = 0; byte_cd = 0; tx_hold = 0; rx_hold = 0;
                cond_done = 0; byte_done = 0; ack_rcvd = 0; rx_full = 0;
                tx_empty = (tx_q.size() == 0);
                tx_data = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
                continue;
            end
            cond_done = 0; byte_done = 0; ack_rcvd = 0; byte_rcvd = 8'($urandom);
            if (cond_cd > 0) begin
                cond_cd--;
                if (cond_cd == 0) begin
                    cond_done = 1;
                    if (cond_stop) stop_cd_cyc = cyc;
                end
            end
            if (byte_cd > 0) begin
                byte_cd--;
                if (byte_cd == 0) begin
                    byte_done = 1; ack_rcvd = ack_plan; byte_rcvd = rd_plan;
                    if (plan_is_read) begin
                        rd_done++;
                        if (rd_done == rx_stall_after) rx_hold = rx_stall_len;
                    end
                end
            end
            if (start_cond) begin n_start++; cond_cd = $urandom_range(1, 3); cond_stop = 0; byte_idx = 0; end
            if (stop_cond)  begin n_stop++;  cond_cd = $urandom_range(1, 3); cond_stop = 1; end
            if (byte_start) begin
                bs_byte.push_back(byte_val); bs_read.push_back(byte_is_read);
                bs_ack.push_back(ack_to_send); bs_cyc.push_back(cyc);
                ack_plan = (byte_idx == nack_at);
                plan_is_read = byte_is_read;
                rd_plan = 8'h00;
                if (byte_is_read && rx_src.size() != 0) rd_plan = rx_src.pop_front();
                byte_idx++;
                byte_cd = $urandom_range(1, max_delay);
            end
            if (r_tx_fifo_en) begin
                popv = 8'hEE;
                if (tx_q.size() != 0) popv = tx_q.pop_front();
                pop_q.push_back(popv); pop_cyc.push_back(cyc);
                if (pop_q.size() == tx_stall_after) tx_hold = tx_stall_len;
            end
            if (w_rx_fifo_en) begin push_q.push_back(rx_data); push_cyc.push_back(cyc); end
            if (done) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
            if (tx_hold > 0) begin
                tx_empty = 1; tx_hold--;
                if (tx_hold == 0) tx_low_cyc = cyc + 1;
            end else begin
                tx_empty = (tx_q.size() == 0);
            end
            tx_data = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
            if (rx_hold > 0) begin
                rx_full = 1; rx_hold--;
                if (rx_hold == 0) rx_low_cyc = cyc + 1;
            end else begin
                rx_full = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        bs_byte.delete(); bs_read.delete(); bs_ack.delete(); bs_cyc.delete();
        pop_q.delete(); pop_cyc.delete(); push_q.delete(); push_cyc.delete();
        exp_bytes.delete(); exp_read.delete(); exp_ack.delete(); exp_pop.delete(); exp_push.delete();
        n_start = 0; n_stop = 0; n_done = 0; rd_done = 0; exp_nack = 0;
        tx_stall_after = 0; rx_stall_after = 0; nack_at = -1;
    endtask

    task automatic load_fifos(input bit r);
        tx_q.delete(); rx_src.delete();
        foreach (cur_data[i]) begin
            if (r) rx_src.push_back(cur_data[i]);
            else   tx_q.push_back(cur_data[i]);
        end
        if (!r) begin tx_q.push_back(8'h3C); tx_q.push_back(8'hC3); end
    endtask

    // Expected activity from the protocol rules: address byte, then data bytes until count or slave NACK
    task automatic expect_txn(input bit r, input logic [6:0] a, input int n, input int nk);
        exp_bytes.push_back({a, r}); exp_read.push_back(0); exp_ack.push_back(0);
        if (nk == 0) begin exp_nack = 1; return; end
        for (int i = 0; i < n; i++) begin
            if (r) begin
                exp_bytes.push_back(8'h00); exp_read.push_back(1); exp_ack.push_back(i == n - 1);
                exp_push.push_back(cur_data[i]);
            end else begin
                exp_bytes.push_back(cur_data[i]); exp_read.push_back(0); exp_ack.push_back(0);
                exp_pop.push_back(cur_data[i]);
                if (nk == i + 1) begin exp_nack = 1; break; end
            end
        end
    endtask

    task automatic start_txn(input bit r, input logic [6:0] a, input int n, input bit rep, input bit keep);
        rw = r; slave_addr = a; byte_count = 8'(n); repeat_start = rep; enable = 1;
        @(posedge clk); #2;
        check("busy_after_enable", busy, 1);
        check("start_after_enable", start_cond, 1);
        check("nack_cleared_on_start", nack_err, 0);
        if (!keep) enable = 0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && n_done < target; i++) begin
            @(posedge clk); #2;
        end
        @(posedge clk); #2;
    endtask

    task automatic compare_logs(input string tag, input int starts, input int stops);
        check({tag, " starts"}, n_start, starts);
        check({tag, " stops"}, n_stop, stops);
        check({tag, " dones"}, n_done, 1);
        check({tag, " nbytes"}, bs_byte.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < bs_byte.size(); i++) begin
            check($sformatf("%s is_read%0d", tag, i), bs_read[i], exp_read[i]);
            if (exp_read[i]) check($sformatf("%s ack_to_send%0d", tag, i), bs_ack[i], exp_ack[i]);
            else             check($sformatf("%s byte%0d", tag, i), bs_byte[i], exp_bytes[i]);
        end
        check({tag, " npops"}, pop_q.size(), exp_pop.size());
        for (int i = 0; i < exp_pop.size() && i < pop_q.size(); i++)
            check($sformatf("%s pop%0d", tag, i), pop_q[i], exp_pop[i]);
        check({tag, " npushes"}, push_q.size(), exp_push.size());
        for (int i = 0; i < exp_push.size() && i < push_q.size(); i++)
            check($sformatf("%s push%0d", tag, i), push_q[i], exp_push[i]);
        check({tag, " nack_err"}, nack_err, exp_nack);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " done_latency"}, done_cyc, stop_cd_cyc + 1);
        check({tag, " busy_at_done"}, busy_at_done, 0);
    endtask

    bit         r;
    logic [6:0] a;
    int         n, nk;

    initial begin : main
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {r_tx_fifo_en, w_rx_fifo_en, rx_data, start_cond, stop_cond, byte_start,
                                byte_val, byte_is_read, ack_to_send, busy, done, nack_err}, 0);
        rst = 0;
        @(posedge clk); #2;
        check("idle_busy", busy, 0);

        // Write three bytes to 0x50
        clear_logs(); max_delay = 3;
        cur_data = '{8'hA1, 8'hA2, 8'hA3};
        load_fifos(0); expect_txn(0, 7'h50, 3, -1);
        start_txn(0, 7'h50, 3, 0, 0); wait_done(1);
        compare_logs("write3", 1, 1);

        // Read two bytes from 0x50
        clear_logs();
        cur_data = '{8'h5C, 8'hC5};
        load_fifos(1); expect_txn(1, 7'h50, 2, -1);
        start_txn(1, 7'h50, 2, 0, 0); wait_done(1);
        compare_logs("read2", 1, 1);
        check("read2 rx_data_held", rx_data, 8'hC5);

        // Address NACK, then a clean transaction clears the flag
        clear_logs(); nack_at = 0;
        cur_data = '{8'h11, 8'h22};
        load_fifos(0); expect_txn(0, 7'h2A, 2, 0);
        start_txn(0, 7'h2A, 2, 0, 0); wait_done(1);
        compare_logs("addr_nack", 1, 1);
        clear_logs();
        cur_data = '{8'h77};
        load_fifos(1); expect_txn(1, 7'h2A, 1, -1);
        start_txn(1, 7'h2A, 1, 0, 0); wait_done(1);
        compare_logs("after_nack", 1, 1);

        // TX empty for 10 cycles before the second data byte
        clear_logs(); max_delay = 2; tx_stall_after = 1; tx_stall_len = 10;
        cur_data = '{8'h01, 8'h02, 8'h03};
        load_fifos(0); expect_txn(0, 7'h33, 3, -1);
        start_txn(0, 7'h33, 3, 0, 0); wait_done(1);
        compare_logs("tx_stall", 1, 1);
        if (pop_cyc.size() > 1) check("tx_stall pop_cycle", pop_cyc[1], tx_low_cyc + 1);
        else                    check("tx_stall second_pop_present", pop_cyc.size(), 3);
        if (bs_cyc.size() > 2)  check("tx_stall byte_start_cycle", bs_cyc[2], tx_low_cyc + 1);
        else                    check("tx_stall second_byte_start_present", bs_cyc.size(), 4);

        // RX full after the first read byte
        clear_logs(); rx_stall_after = 1; rx_stall_len = 8;
        cur_data = '{8'h9E, 8'h4B};
        load_fifos(1); expect_txn(1, 7'h33, 2, -1);
        start_txn(1, 7'h33, 2, 0, 0); wait_done(1);
        compare_logs("rx_stall", 1, 1);
        if (push_cyc.size() > 0) check("rx_stall push_cycle", push_cyc[0], rx_low_cyc + 1);
        else                     check("rx_stall first_push_present", push_cyc.size(), 2);

        // Write one byte, repeated START, read one byte
        clear_logs(); max_delay = 3;
        tx_q.delete(); rx_src.delete();
        tx_q.push_back(8'hD4); rx_src.push_back(8'h6B);
        cur_data = '{8'hD4}; expect_txn(0, 7'h41, 1, -1);
        cur_data = '{8'h6B}; expect_txn(1, 7'h41, 1, -1);
        start_txn(0, 7'h41, 1, 1, 1);
        rw = 1; byte_count = 8'd1;
        for (int i = 0; i < 500 && n_start < 2; i++) begin @(posedge clk); #2; end
        enable = 0; repeat_start = 0;
        wait_done(1);
        compare_logs("rep_start", 2, 1);

        // Reset while a data byte is in flight, then an address-only write
        clear_logs();
        cur_data = '{8'hB1, 8'hB2, 8'hB3};
        load_fifos(0);
        start_txn(0, 7'h12, 3, 0, 0);
        for (int i = 0; i < 500 && pop_q.size() < 1; i++) begin @(posedge clk); #2; end
        rst = 1;
        @(posedge clk); #2;
        check("mid_reset_outputs", {r_tx_fifo_en, w_rx_fifo_en, rx_data, start_cond, stop_cond, byte_start,
                                    byte_val, byte_is_read, ack_to_send, busy, done, nack_err}, 0);
        rst = 0;
        @(posedge clk); #2;
        clear_logs();
        cur_data.delete();
        load_fifos(0); expect_txn(0, 7'h12, 0, -1);
        start_txn(0, 7'h12, 0, 0, 0); wait_done(1);
        compare_logs("addr_only", 1, 1);

        // Random transactions with random delays, stalls and NACK positions
        for (int t = 0; t < 14; t++) begin
            clear_logs();
            r = 1'($urandom_range(0, 1));
            a = 7'($urandom);
            n = $urandom_range(0, 4);
            cur_data.delete();
            for (int i = 0; i < n; i++) cur_data.push_back(8'($urandom));
            nk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n)) : -1;
            nack_at = nk;
            max_delay = $urandom_range(1, 4);
            tx_stall_after = $urandom_range(1, 4); tx_stall_len = $urandom_range(0, 6);
            rx_stall_after = $urandom_range(1, 4); rx_stall_len = $urandom_range(0, 6);
            load_fifos(r);
            expect_txn(r, a, n, r ? ((nk == 0) ? 0 : -1) : nk);
            start_txn(r, a, n, 0, 0); wait_done(1);
            compare_logs($sformatf("rand%0d", t), 1, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
